if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the PC, issues word fetches to instruction memory over a req/ack handshake that tolerates variable latency, and buffers returned words in a 2-entry fetch queue. The queue head is presented to IF/ID as {instruction, PC+4}. Handles hazard-unit hold and branch/jump redirect, including discarding in-flight fetches.

---
 rtl/if_fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack fetch, 2-entry fetch queue, hold and redirect.
// Optional perf counters (fetchCount/stallCount) are enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrOut,
  output logic [31:0] PCplus4,
  output logic        instrValid,
  output logic        IF_flush
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
`endif
);

  localparam logic [0:0] ST_REQ     = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [31:0] pc_r;
  logic [31:0] addr_r;
  logic        pending_r;
  logic [0:0]  state_r;
  logic [1:0]  count_r;
  logic [31:0] instr0_r, instr1_r;
  logic [31:0] pc4_0_r, pc4_1_r;

  logic        req_s;
  logic [31:0] fetch_addr_s;
  logic [31:0] fetch_pc4_s;
  logic        ack_s;
  logic        push_s;
  logic        pop_s;
  logic        head_valid_s;

  // Request/queue control; an outstanding request keeps its captured address across redirects.
  always_comb begin
    req_s        = !rst && (pending_r || (count_r < 2'd2));
    fetch_addr_s = pending_r ? addr_r : pc_r;
    fetch_pc4_s  = fetch_addr_s + 32'd4;
    ack_s        = req_s && imem_ack;
    push_s       = ack_s && (state_r == ST_REQ) && !redirect;
    head_valid_s = (count_r != 2'd0) && !redirect;
    pop_s        = head_valid_s && !hold;
  end

  // Outputs to imem and IF/ID; a redirect forces a bubble into IF/ID.
  always_comb begin
    imem_req   = req_s;
    imem_addr  = fetch_addr_s;
    instrValid = head_valid_s;
    IF_flush   = redirect;
    if (head_valid_s) begin
      instrOut = instr0_r;
      PCplus4  = pc4_0_r;
    end else begin
      instrOut = 32'h0000_0000;
      PCplus4  = 32'h0000_0000;
    end
  end

  // PC, handshake state, discard FSM and fetch queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      addr_r    <= RESET_PC;
      pending_r <= 1'b0;
      state_r   <= ST_REQ;
      count_r   <= 2'd0;
      instr0_r  <= 32'h0000_0000;
      instr1_r  <= 32'h0000_0000;
      pc4_0_r   <= 32'h0000_0000;
      pc4_1_r   <= 32'h0000_0000;
    end else begin
      if (ack_s) begin
        pending_r <= 1'b0;
      end else if (req_s) begin
        pending_r <= 1'b1;
      end
      if (req_s && !pending_r) begin
        addr_r <= pc_r;
      end
      if (redirect) begin
        pc_r    <= redirectPC & 32'hFFFF_FFFC;
        count_r <= 2'd0;
        // A request already on the bus cannot be withdrawn; its data must be thrown away.
        state_r <= (req_s && !imem_ack) ? ST_DISCARD : ST_REQ;
      end else begin
        if (ack_s) begin
          state_r <= ST_REQ;
        end
        if (push_s) begin
          pc_r <= fetch_pc4_s;
        end
        case ({push_s, pop_s})
          2'b10: begin
            if (count_r == 2'd0) begin
              instr0_r <= imem_rdata;
              pc4_0_r  <= fetch_pc4_s;
            end else begin
              instr1_r <= imem_rdata;
              pc4_1_r  <= fetch_pc4_s;
            end
            count_r <= count_r + 2'd1;
          end
          2'b01: begin
            instr0_r <= instr1_r;
            pc4_0_r  <= pc4_1_r;
            count_r  <= count_r - 2'd1;
          end
          2'b11: begin
            if (count_r == 2'd1) begin
              instr0_r <= imem_rdata;
              pc4_0_r  <= fetch_pc4_s;
            end else begin
              instr0_r <= instr1_r;
              pc4_0_r  <= pc4_1_r;
              instr1_r <= imem_rdata;
              pc4_1_r  <= fetch_pc4_s;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Pop and held-valid counters, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (pop_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      if (hold && head_valid_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign fetchCount = fetch_cnt_r;
  assign stallCount = stall_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: queue-based reference model, variable-latency memory.
// Define IF_FETCH_PERF_CNT_EN to also exercise the perf counters.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, hold, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instrValid, IF_flush;
  logic [31:0] imem_addr, instrOut, PCplus4;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetchCount, stallCount;
`endif

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .hold(hold), .redirect(redirect), .redirectPC(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instrOut(instrOut), .PCplus4(PCplus4), .instrValid(instrValid), .IF_flush(IF_flush)
`ifdef IF_FETCH_PERF_CNT_EN
    , .fetchCount(fetchCount), .stallCount(stallCount)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: program counter, queue of {instr, pc+4}, outstanding request bookkeeping.
  logic [31:0] m_pc, m_addr;
  bit          m_pending, m_discard;
  logic [63:0] q[$];
  int          m_fetch, m_stall;
  int          mem_wait, lat;
  bit          force_ack;
  logic [98:0] exp_vec, obs_vec;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2400_0001;
  endfunction

  task automatic m_reset();
    m_pc = RESET_PC; m_addr = RESET_PC; m_pending = 0; m_discard = 0;
    q.delete(); m_fetch = 0; m_stall = 0; mem_wait = 0;
  endtask

  // One clock: predict outputs, answer memory, sample DUT, advance model, return at next negedge.
  task automatic tick();
    bit ereq, ev, acked;
    logic [31:0] eaddr;
    logic [63:0] h;
    ereq  = !rst && (m_pending || q.size() < 2);
    eaddr = m_pending ? m_addr : m_pc;
    ev    = (q.size() > 0) && !redirect;
    h     = ev ? q[0] : 64'h0;
    exp_vec = {ereq, eaddr, ev, h[63:32], h[31:0], redirect};
    if (force_ack) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
    end else if (ereq && mem_wait >= lat) begin
      imem_ack = 1'b1; imem_rdata = mem_word(eaddr); mem_wait = 0;
    end else begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      mem_wait = ereq ? mem_wait + 1 : 0;
    end
    #1;
    obs_vec = {imem_req, imem_addr, instrValid, instrOut, PCplus4, IF_flush};
    acked = ereq && imem_ack;
    if (rst) begin
      m_reset();
    end else begin
      if (ev && !hold) m_fetch++;
      if (ev && hold) m_stall++;
      if (redirect) begin
        q.delete();
        if (acked) begin
          m_pending = 0; m_discard = 0;
        end else if (ereq) begin
          m_pending = 1; m_discard = 1; m_addr = eaddr;
        end
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (ev && !hold) void'(q.pop_front());
        if (acked) begin
          if (!m_discard) begin
            q.push_back({imem_rdata, eaddr + 32'd4});
            m_pc = eaddr + 32'd4;
          end
          m_pending = 0; m_discard = 0;
        end else if (ereq) begin
          m_pending = 1; m_addr = eaddr;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] k4;
    rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; force_ack = 1'b0; lat = 0;
    m_reset();
    tick();
    n_tests++;
    if (obs_vec[98] !== 1'b0) begin n_fail++; $display("FAIL reset_req0: got %b want 0", obs_vec[98]); end
    tick();
    n_tests++;
    if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs_vec, exp_vec); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      k4 = 32'(k) * 32'd4;
      n_tests++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL zero_wait_model k=%0d: got %h want %h", k, obs_vec, exp_vec); end
      n_tests++;
      if (obs_vec[97:66] !== k4) begin n_fail++; $display("FAIL zero_wait_addr k=%0d: got %h want %h", k, obs_vec[97:66], k4); end
      if (k > 0) begin
        n_tests++;
        if (obs_vec[32:1] !== k4 || obs_vec[65] !== 1'b1) begin
          n_fail++; $display("FAIL zero_wait_pc4 k=%0d: got %h/%b want %h/1", k, obs_vec[32:1], obs_vec[65], k4);
        end
      end
    end
  endtask

  task automatic test_hold();
    lat = 3;
    for (int i = 0; i < 5; i++) begin
      tick(); n_tests++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL hold_pre %0d: got %h want %h", i, obs_vec, exp_vec); end
    end
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); n_tests++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL hold_on %0d: got %h want %h", i, obs_vec, exp_vec); end
    end
    n_tests++;
    if (obs_vec[98] !== 1'b0) begin n_fail++; $display("FAIL hold_req_drop: got %b want 0", obs_vec[98]); end
    hold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(); n_tests++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL hold_release %0d: got %h want %h", i, obs_vec, exp_vec); end
      if (i < 2) begin
        n_tests++;
        if (obs_vec[65] !== 1'b1) begin n_fail++; $display("FAIL hold_pop %0d: got %b want 1", i, obs_vec[65]); end
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    bit found, seen_valid;
    rst = 1'b1; tick(); rst = 1'b0; lat = 4;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(); n_tests++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rdo_pre %0d: got %h want %h", i, obs_vec, exp_vec); end
      if (exp_vec[98] && exp_vec[97:66] == 32'h8) found = 1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rdo_find_req8: got none want req of 0x8"); end
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick(); n_tests++;
    if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rdo_redirect: got %h want %h", obs_vec, exp_vec); end
    redirect = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 40 && !seen_valid; i++) begin
      tick(); n_tests++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rdo_post %0d: got %h want %h", i, obs_vec, exp_vec); end
      if (obs_vec[65] === 1'b1) begin
        seen_valid = 1; n_tests++;
        if (obs_vec[32:1] !== 32'h104) begin n_fail++; $display("FAIL rdo_first_pc4: got %h want 104", obs_vec[32:1]); end
      end
    end
    n_tests++;
    if (!seen_valid) begin n_fail++; $display("FAIL rdo_timeout: got no valid head want pc4 104"); end
  endtask

  task automatic test_redirect_ack_hold();
    logic [31:0] tgt;
    lat = 0;
    for (int i = 0; i < 6; i++) tick();
    tgt = 32'h0000_0200 + (32'($urandom_range(0, 255)) << 2);
    redirect = 1'b1; hold = 1'b1; redirect_pc = tgt;
    tick(); n_tests++;
    if (obs_vec !== exp_vec || obs_vec[98] !== 1'b1 || obs_vec[65] !== 1'b0 || obs_vec[0] !== 1'b1) begin
      n_fail++; $display("FAIL rah_cycle: got %h want %h (req=1 valid=0 flush=1)", obs_vec, exp_vec);
    end
    redirect = 1'b0; hold = 1'b0;
    tick(); n_tests++;
    if (obs_vec[97:66] !== tgt || obs_vec[65] !== 1'b0) begin
      n_fail++; $display("FAIL rah_next_addr: got %h/%b want %h/0", obs_vec[97:66], obs_vec[65], tgt);
    end
  endtask

  task automatic test_wrap_reset();
    lat = 0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick(); redirect = 1'b0;
    tick(); n_tests++;
    if (obs_vec[97:66] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", obs_vec[97:66]); end
    tick(); n_tests++;
    if (obs_vec[97:66] !== 32'h0 || obs_vec[32:1] !== 32'h0 || obs_vec[65] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_next: got addr %h pc4 %h v %b want 0 0 1", obs_vec[97:66], obs_vec[32:1], obs_vec[65]);
    end
    lat = 5;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1; tick();
    force_ack = 1'b1; tick(); force_ack = 1'b0;
    rst = 1'b0;
    tick(); n_tests++;
    if (obs_vec !== exp_vec || obs_vec[97:66] !== RESET_PC || obs_vec[65] !== 1'b0 || obs_vec[98] !== 1'b1) begin
      n_fail++; $display("FAIL reset_midop: got %h want %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (mem_wait == 0) lat = $urandom_range(0, 3);
      hold = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 99) < 8);
      redirect_pc = $urandom;
      tick(); n_tests++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random %0d: got %h want %h", i, obs_vec, exp_vec); end
    end
    redirect = 1'b0; hold = 1'b0;
  endtask

`ifdef IF_FETCH_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1; lat = 0; tick(); rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    hold = 1'b0;
    n_tests++;
    if (fetchCount !== 32'(m_fetch) || fetchCount !== 32'd5) begin
      n_fail++; $display("FAIL perf_fetch: got %0d want %0d", fetchCount, m_fetch);
    end
    n_tests++;
    if (stallCount !== 32'(m_stall) || stallCount !== 32'd3) begin
      n_fail++; $display("FAIL perf_stall: got %0d want %0d", stallCount, m_stall);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; force_ack = 1'b0; lat = 0;
    @(negedge clk);
    test_reset();
    test_hold();
    test_redirect_outstanding();
    test_redirect_ack_hold();
    test_wrap_reset();
    test_random();
`ifdef IF_FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
